// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes and FSM state encodings for the sequential ALU
package alu_seq_pkg;
  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_ORR   = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_LSL   = 4'd3;
  localparam logic [3:0] ALU_LSR   = 4'd4;
  localparam logic [3:0] ALU_MUL   = 4'd5;
  localparam logic [3:0] ALU_SUB   = 4'd6;
  localparam logic [3:0] ALU_PASSB = 4'd7;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MULT} state_t;
endpackage

// File: rtl/alu_seq_mul_iter.sv
// mul_iter: radix-2 shift-add multiplier, one multiplier bit per cycle, low WIDTH bits kept
module mul_iter #(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [WIDTH-1:0] mc_q, mc_d, mp_q, mp_d, p_q, p_d, mc_s, mp_s, p_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, step;
  // the first iteration is folded into the load edge so the product is final after WIDTH edges
  always_comb begin
    done = busy_q && cnt_q == CW'(WIDTH);
    step = go || (busy_q && !done);
    mc_s = go ? a : mc_q;
    mp_s = go ? b : mp_q;
    p_s = go ? '0 : p_q;
    p_d = step ? p_s + (mp_s[0] ? mc_s : '0) : p_q;
    mc_d = step ? mc_s << 1 : mc_q;
    mp_d = step ? mp_s >> 1 : mp_q;
    cnt_d = go ? CW'(1) : step ? cnt_q + CW'(1) : cnt_q;
    busy_d = go || (busy_q && !done);
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      mc_q <= '0;
      mp_q <= '0;
      p_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      mc_q <= mc_d;
      mp_q <= mp_d;
      p_q <= p_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
  end
  assign busy = busy_q;
  assign p = p_q;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with registered result/NZCV and Start/Ready/Done handshake
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow
);
  state_t state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, w_q, w_d, res, mul_p;
  logic [WIDTH:0] sum, dif;
  logic z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, done_q, done_d;
  logic accept, fin, res_c, res_v, mul_go, mul_busy, mul_done;
  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .CLK(CLK), .Reset(Reset), .go(mul_go), .a(BusA), .b(BusB),
    .busy(mul_busy), .done(mul_done), .p(mul_p)
  );
  always_comb begin
    accept = state_q == S_IDLE && Start;
    mul_go = accept && ALUCtrl == ALU_MUL;
    sum = {1'b0, a_q} + {1'b0, b_q};
    dif = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
    res = op_q == ALU_AND   ? a_q & b_q :
          op_q == ALU_ORR   ? a_q | b_q :
          op_q == ALU_ADD   ? sum[WIDTH-1:0] :
          op_q == ALU_LSL   ? a_q << b_q[SHW-1:0] :
          op_q == ALU_LSR   ? a_q >> b_q[SHW-1:0] :
          op_q == ALU_SUB   ? dif[WIDTH-1:0] :
          op_q == ALU_PASSB ? b_q : '0;
    res_c = op_q == ALU_ADD ? sum[WIDTH] : op_q == ALU_SUB && dif[WIDTH];
    res_v = op_q == ALU_ADD ? a_q[WIDTH-1] == b_q[WIDTH-1] && sum[WIDTH-1] != a_q[WIDTH-1] :
            op_q == ALU_SUB && a_q[WIDTH-1] != b_q[WIDTH-1] && dif[WIDTH-1] != a_q[WIDTH-1];
    fin = state_q == S_EXEC || (state_q == S_MULT && mul_busy && mul_done);
    state_d = accept ? (ALUCtrl == ALU_MUL ? S_MULT : S_EXEC) : fin ? S_IDLE : state_q;
    op_d = accept ? ALUCtrl : op_q;
    a_d = accept ? BusA : a_q;
    b_d = accept ? BusB : b_q;
    w_d = !fin ? w_q : state_q == S_MULT ? mul_p : res;
    z_d = fin ? w_d == '0 : z_q;
    n_d = fin ? w_d[WIDTH-1] : n_q;
    c_d = fin ? state_q == S_EXEC && res_c : c_q;
    v_d = fin ? state_q == S_EXEC && res_v : v_q;
    done_d = fin;
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      w_q <= '0;
      z_q <= 1'b1;
      n_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      w_q <= w_d;
      z_q <= z_d;
      n_q <= n_d;
      c_q <= c_d;
      v_q <= v_d;
      done_q <= done_d;
    end
  end
  assign Ready = state_q == S_IDLE;
  assign Done = done_q;
  assign BusW = w_q;
  assign Zero = z_q;
  assign Negative = n_q;
  assign Carry = c_q;
  assign Overflow = v_q;
endmodule
